// File: rtl/simd_issue_if.sv
// Request/issue/writeback bundle between warp requesters and the SIMD issue scheduler.
// master = requester side, slave = scheduler side.
interface simd_issue_if #(
    parameter int NUM_WARPS = 4
);
    localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NUM_WARPS-1:0]    req_valid;
    logic [32*NUM_WARPS-1:0] req_instr;
    logic [NUM_WARPS-1:0]    req_ready;

    logic                    issue_valid;
    logic [WARP_W-1:0]       issue_warp;
    logic [1:0]              issue_op;
    logic [3:0]              issue_mask;
    logic [2:0]              issue_dest;
    logic [2:0]              issue_srcA;
    logic [2:0]              issue_srcB;

    logic                    wb_valid;
    logic [2:0]              wb_dest;
    logic [WARP_W-1:0]       wb_warp;

    modport master (
        output req_valid, req_instr,
        input  req_ready,
        input  issue_valid, issue_warp, issue_op, issue_mask, issue_dest, issue_srcA, issue_srcB,
        input  wb_valid, wb_dest, wb_warp
    );

    modport slave (
        input  req_valid, req_instr,
        output req_ready,
        output issue_valid, issue_warp, issue_op, issue_mask, issue_dest, issue_srcA, issue_srcB,
        output wb_valid, wb_dest, wb_warp
    );
endinterface

// File: rtl/simd_issue_scheduler.sv
// Round-robin issue scheduler sharing one SIMD ALU among NUM_WARPS streams, with a
// destination scoreboard and a fixed-latency writeback strobe.
module simd_issue_scheduler #(
    parameter int NUM_WARPS  = 4,
    parameter int WB_LATENCY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    simd_issue_if.slave      bus,
    output logic [7:0]       pending,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_count
);
    localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [31:0]          instr_w [NUM_WARPS];
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant;
    logic [WARP_W-1:0]    sel;
    logic [WARP_W-1:0]    idx;
    logic [31:0]          sel_instr;
    logic [WARP_W-1:0]    last_grant;
    logic                 xfer;
    logic [7:0]           set_vec;
    logic [7:0]           clr_vec;

    logic                 pipe_v [WB_LATENCY+1];
    logic [2:0]           pipe_d [WB_LATENCY+1];
    logic [WARP_W-1:0]    pipe_w [WB_LATENCY+1];

    function automatic logic [WARP_W-1:0] rr_idx(input logic [WARP_W-1:0] base, input int off);
        int s;
        s = int'(base) + 1 + off;
        if (s >= NUM_WARPS) s = s - NUM_WARPS;
        return WARP_W'(s);
    endfunction

    // Hazard check: a source or a nonzero destination with a write in flight blocks the warp.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [2:0] d, a, b;
        assign instr_w[w]  = bus.req_instr[32*w +: 32];
        assign d           = instr_w[w][25:23];
        assign a           = instr_w[w][22:20];
        assign b           = instr_w[w][19:17];
        assign eligible[w] = run & bus.req_valid[w] & ~pending[a] & ~pending[b]
                             & ((d == 3'd0) | ~pending[d]);
    end

    always_comb begin
        grant     = '0;
        sel       = '0;
        idx       = '0;
        sel_instr = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_idx(last_grant, i);
            if ((grant == '0) && eligible[idx]) begin
                grant[idx] = 1'b1;
                sel        = idx;
                sel_instr  = instr_w[idx];
            end
        end
    end

    assign bus.req_ready = grant;
    assign xfer          = |grant;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (xfer && (sel_instr[25:23] != 3'd0)) set_vec = 8'b1 << sel_instr[25:23];
        if (pipe_v[WB_LATENCY])                 clr_vec = 8'b1 << pipe_d[WB_LATENCY];
    end

    assign bus.wb_valid = pipe_v[WB_LATENCY];
    assign bus.wb_dest  = pipe_d[WB_LATENCY];
    assign bus.wb_warp  = pipe_w[WB_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.issue_valid <= 1'b0;
            bus.issue_warp  <= '0;
            bus.issue_op    <= '0;
            bus.issue_mask  <= '0;
            bus.issue_dest  <= '0;
            bus.issue_srcA  <= '0;
            bus.issue_srcB  <= '0;
            last_grant      <= WARP_W'(NUM_WARPS - 1);
            pending         <= '0;
            issue_count     <= '0;
            stall_count     <= '0;
            for (int k = 0; k <= WB_LATENCY; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_d[k] <= '0;
                pipe_w[k] <= '0;
            end
        end else begin
            bus.issue_valid <= xfer;
            if (xfer) begin
                bus.issue_warp <= sel;
                bus.issue_op   <= sel_instr[31:30];
                bus.issue_mask <= sel_instr[29:26];
                bus.issue_dest <= sel_instr[25:23];
                bus.issue_srcA <= sel_instr[22:20];
                bus.issue_srcB <= sel_instr[19:17];
                last_grant     <= sel;
                issue_count    <= issue_count + CNT_W'(1);
            end
            if ((|bus.req_valid) && !xfer && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);

            // Stage 0 lines up with the issue cycle, so the last stage lands WB_LATENCY cycles later.
            pipe_v[0] <= set_vec != 8'd0;
            pipe_d[0] <= sel_instr[25:23];
            pipe_w[0] <= sel;
            for (int k = 1; k <= WB_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
                pipe_w[k] <= pipe_w[k-1];
            end

            pending <= (pending | set_vec) & ~clr_vec & 8'hFE;
        end
    end
endmodule
